// File: rtl/i2c_target_responder_if.sv
// i2c_target_responder_if: I2C pins plus local host-write and write-notify signals
interface i2c_target_responder_if;
  logic       scl, sda_in, sda_oe, host_wr_en, wr_valid, busy;
  logic [7:0] host_wr_index, host_wr_data, wr_index, wr_data;
  modport slave (
    input  scl, sda_in, host_wr_en, host_wr_index, host_wr_data,
    output sda_oe, wr_valid, wr_index, wr_data, busy
  );
  modport master (
    output scl, sda_in, host_wr_en, host_wr_index, host_wr_data,
    input  sda_oe, wr_valid, wr_index, wr_data, busy
  );
endinterface

// File: rtl/i2c_target_responder.sv
// i2c_target_responder: oversampled I2C target with a 256-byte auto-incrementing register file
module i2c_target_responder #(
  parameter logic [6:0] DEVICE_ADDR = 7'h39,
  parameter int         SYNC_STAGES = 2
) (
  input logic                   clk,
  input logic                   rst,
  i2c_target_responder_if.slave bus
);
  localparam logic [3:0] IDLE = 4'd0, ADDR = 4'd1, ADDR_ACK = 4'd2, INDEX = 4'd3, INDEX_ACK = 4'd4,
                         WDATA = 4'd5, WDATA_ACK = 4'd6, RDATA = 4'd7, RDATA_ACK = 4'd8, IGNORE = 4'd9;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic       scl_h_q, sda_h_q, scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;
  logic [3:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, ptr_q, ptr_d, byte_c, rd_c;
  logic [7:0] wr_index_q, wr_index_d, wr_data_q, wr_data_d;
  logic       sda_oe_q, sda_oe_d, busy_q, busy_d, wr_valid_q, wr_valid_d;
  logic       i2c_we, ack_st, shift_st;
  logic [7:0] rf_q [256];
  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_h_q;
  assign scl_fall = ~scl_s & scl_h_q;
  assign start_c  = scl_s & scl_h_q & sda_h_q & ~sda_s;
  assign stop_c   = scl_s & scl_h_q & ~sda_h_q & sda_s;
  assign byte_c   = {shift_q[6:0], sda_s};
  assign rd_c     = rf_q[ptr_q];
  assign ack_st   = state_q inside {ADDR_ACK, INDEX_ACK, WDATA_ACK, RDATA_ACK};
  assign shift_st = state_q inside {ADDR, INDEX, WDATA, RDATA};
  // In ACK states cnt_q marks whether the 9th rising edge has been seen (0 = not yet)
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_index_d = wr_index_q;
    wr_data_d  = wr_data_q;
    i2c_we     = 1'b0;
    if (start_c) begin
      state_d  = ADDR;
      cnt_d    = 3'd0;
      sda_oe_d = 1'b0;
    end else if (stop_c) begin
      state_d  = IDLE;
      cnt_d    = 3'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (scl_rise) begin
      if (ack_st) begin
        cnt_d   = 3'd1;
        state_d = (state_q == RDATA_ACK && sda_s) ? IGNORE : state_q;
      end else if (shift_st) begin
        shift_d = byte_c;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          case (state_q)
            ADDR: begin
              state_d = (byte_c[7:1] == DEVICE_ADDR) ? ADDR_ACK : IGNORE;
              busy_d  = busy_q | (byte_c[7:1] == DEVICE_ADDR);
            end
            INDEX: begin
              ptr_d   = byte_c;
              state_d = INDEX_ACK;
            end
            WDATA: begin
              i2c_we     = 1'b1;
              wr_valid_d = 1'b1;
              wr_index_d = ptr_q;
              wr_data_d  = byte_c;
              ptr_d      = ptr_q + 8'd1;
              state_d    = WDATA_ACK;
            end
            default: begin
              ptr_d   = ptr_q + 8'd1;
              state_d = RDATA_ACK;
            end
          endcase
        end
      end
    end else if (scl_fall) begin
      if (state_q == RDATA) sda_oe_d = ~shift_q[7];
      else if (ack_st && cnt_q == 3'd0) sda_oe_d = state_q != RDATA_ACK;
      else if (ack_st) begin
        cnt_d = 3'd0;
        if ((state_q == ADDR_ACK && shift_q[0]) || state_q == RDATA_ACK) begin
          state_d  = RDATA;
          shift_d  = rd_c;
          sda_oe_d = ~rd_c[7];
        end else begin
          state_d  = (state_q == ADDR_ACK) ? INDEX : WDATA;
          sda_oe_d = 1'b0;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl};
    sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
    scl_h_q    <= scl_s;
    sda_h_q    <= sda_s;
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= 8'd0;
      ptr_q      <= 8'd0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_index_q <= 8'd0;
      wr_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_index_q <= wr_index_d;
      wr_data_q  <= wr_data_d;
    end
  end
  // An I2C write in the same cycle drops any host write
  always_ff @(posedge clk) begin
    if (i2c_we && !rst) rf_q[ptr_q] <= byte_c;
    else if (bus.host_wr_en) rf_q[bus.host_wr_index] <= bus.host_wr_data;
  end
  assign bus.sda_oe   = sda_oe_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_index = wr_index_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_i2c_target_responder.sv
// tb_i2c_target_responder: bit-banged I2C initiator with scoreboarded ACK/read and write-notify checks
module tb_i2c_target_responder;
  logic clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1, watch_oe = 1'b0;
  logic r_tb;
  logic [7:0] a72 = 8'h72;
  int total = 0, bad = 0, mon_v;
  int rx_exp[$], rx_obs[$], wr_exp[$];
  i2c_target_responder_if bus();
  i2c_target_responder dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.scl    = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(posedge clk) while (rx_obs.size() > 0) begin
    mon_v = rx_obs.pop_front();
    if (rx_exp.size() == 0) chk("rx_unexpected", mon_v, -1);
    else chk("rx", mon_v, rx_exp.pop_front());
  end
  always @(negedge clk) begin
    if (bus.wr_valid) begin
      if (wr_exp.size() == 0) chk("wr_unexpected", {bus.wr_index, bus.wr_data}, -1);
      else chk("wr", {bus.wr_index, bus.wr_data}, wr_exp.pop_front());
    end
    if (watch_oe) chk("nack_oe", bus.sda_oe, 0);
  end
  task automatic q;
    repeat (8) @(posedge clk);
    #1;
  endtask
  task automatic bit_io(input logic b, output logic r);
    sda_m = b; q();
    scl_m = 1'b1; q();
    r = bus.sda_in; q();
    scl_m = 1'b0; q();
  endtask
  task automatic start;
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    sda_m = 1'b0; q();
    scl_m = 1'b0; q();
  endtask
  task automatic stop;
    sda_m = 1'b0; q();
    scl_m = 1'b1; q();
    sda_m = 1'b1; q();
  endtask
  task automatic wbyte(input logic [7:0] b, input int a);
    logic r;
    rx_exp.push_back(a);
    for (int i = 7; i >= 0; i--) bit_io(b[i], r);
    bit_io(1'b1, r);
    rx_obs.push_back(int'(r));
  endtask
  task automatic rbyte(input logic [7:0] e, input logic ack);
    logic r;
    logic [7:0] v;
    rx_exp.push_back(int'(e));
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r);
      v[i] = r;
    end
    bit_io(ack, r);
    rx_obs.push_back(int'(v));
  endtask
  task automatic host_wr(input logic [7:0] i, input logic [7:0] d);
    bus.host_wr_index = i;
    bus.host_wr_data  = d;
    bus.host_wr_en    = 1'b1;
    @(posedge clk); #1;
    bus.host_wr_en    = 1'b0;
  endtask
  initial begin
    bus.host_wr_en = 1'b0; bus.host_wr_index = 8'd0; bus.host_wr_data = 8'd0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_sda_oe", bus.sda_oe, 0);
    chk("rst_wr_valid", bus.wr_valid, 0);
    chk("rst_wr_index", bus.wr_index, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0; q();
    start(); wbyte(8'h72, 0);
    chk("busy_addressed", bus.busy, 1);
    wbyte(8'h41, 0);
    wr_exp.push_back(16'h4110);
    wbyte(8'h10, 0);
    stop();
    chk("busy_after_stop", bus.busy, 0);
    host_wr(8'h42, 8'h60);
    host_wr(8'h43, 8'h35);
    start(); wbyte(8'h73, 0); rbyte(8'h60, 1'b1); stop();
    start(); wbyte(8'h72, 0); wbyte(8'hFE, 0);
    wr_exp.push_back(16'hFEAA); wr_exp.push_back(16'hFFBB); wr_exp.push_back(16'h00CC);
    wbyte(8'hAA, 0); wbyte(8'hBB, 0); wbyte(8'hCC, 0);
    stop();
    start(); wbyte(8'h72, 0); wbyte(8'h42, 0);
    start(); wbyte(8'h73, 0); rbyte(8'h60, 1'b0); rbyte(8'h35, 1'b1);
    chk("read_nack_release", bus.sda_oe, 0);
    stop();
    chk("busy_after_read", bus.busy, 0);
    start(); wbyte(8'h72, 0); wbyte(8'hFE, 0);
    start(); wbyte(8'h73, 0); rbyte(8'hAA, 1'b0); rbyte(8'hBB, 1'b0); rbyte(8'hCC, 1'b1); stop();
    watch_oe = 1'b1;
    start(); wbyte(8'h74, 1);
    chk("busy_foreign", bus.busy, 0);
    wbyte(8'h41, 1); wbyte(8'h99, 1);
    stop();
    watch_oe = 1'b0;
    start(); wbyte(8'h72, 0); wbyte(8'h41, 0);
    for (int i = 7; i >= 3; i--) bit_io(a72[i], r_tb);
    stop();
    start(); wbyte(8'h73, 0); rbyte(8'h10, 1'b1); stop();
    start();
    for (int i = 7; i >= 0; i--) bit_io(a72[i], r_tb);
    sda_m = 1'b1;
    chk("ack_before_rst", bus.sda_oe, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("oe_after_rst", bus.sda_oe, 0);
    chk("busy_after_rst", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    stop();
    start(); wbyte(8'h73, 0); rbyte(8'hCC, 1'b1); stop();
    q();
    chk("rx_left", rx_exp.size(), 0);
    chk("wr_left", wr_exp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_target_responder.md
Name: i2c_target_responder

Overview:
- Synthesizable I2C target (responder) that models the ADV7513 register port seen by the I2C initiator subsystem.
- Oversamples SCL/SDA on a fast system clock and keeps a 256-byte register file with an auto-incrementing index pointer.
- Acknowledges writes and serves reads.
- Used on-chip as a loopback target for initiator bring-up and as the bench counterpart in simulation.

Parameters:
- DEVICE_ADDR, 7'h39, 7-bit target address; the 8-bit write form is 0x72.
- SYNC_STAGES, 2, synchronizer flops on SCL and SDA (minimum 2).

Ports:
- Clock  in  1  system clock; must be at least 16x the SCL frequency.
- Reset  in  1  synchronous, active-high reset.
- SCL  in  1  I2C clock from the bus, asynchronous.
- SDA_In  in  1  I2C data sampled from the bus, asynchronous.
- SDA_OE  out  1  1 = pull SDA low; 0 = release SDA (open-drain).
- Host_Wr_En  in  1  local write strobe into the register file.
- Host_Wr_Index  in  8  local write index.
- Host_Wr_Data  in  8  local write data.
- Wr_Valid  out  1  one-cycle pulse for each byte written over I2C.
- Wr_Index  out  8  register index of the last I2C write.
- Wr_Data  out  8  data of the last I2C write.
- Busy  out  1  high from START to STOP while this target is addressed.

Behaviour:
- Reset values:
  - SDA_OE=0, Wr_Valid=0, Wr_Index=0, Wr_Data=0, Busy=0.
  - pointer=0, state=IDLE, bit counter=0.
  - Register file contents are not reset.
- Input path:
  - SCL and SDA_In each pass through SYNC_STAGES flops, then one history flop.
  - Edge and condition detect latency is SYNC_STAGES+1 Clock cycles after the pin change.
- Bus conditions:
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - START is valid in any state, including repeated START mid-byte: bit counter clears, next state is ADDR, SDA_OE=0 in the same cycle.
  - STOP in any state: next state is IDLE, SDA_OE=0, Busy=0.
- Sampling and driving:
  - Data is sampled on the synchronized SCL rising edge, MSB first.
  - SDA_OE changes only on the synchronized SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - If the upper 7 bits equal DEVICE_ADDR, go to ADDR_ACK and assert Busy.
    - Otherwise go to IGNORE (SDA released until START/STOP).
  - ADDR_ACK:
    - Drive ACK (SDA_OE=1) from the falling edge after bit 8 until the falling edge after the 9th clock.
    - If R/W=0, go to INDEX.
    - If R/W=1, load the shift register from regfile[pointer] and go to RDATA.
  - INDEX: shift 8 bits, then pointer <= byte, then INDEX_ACK (ACK driven), then WDATA.
  - WDATA: shift 8 bits, then on the 8th rising edge:
    - regfile[pointer] <= byte.
    - Wr_Valid pulses for 1 cycle; Wr_Index=pointer, Wr_Data=byte.
    - pointer <= pointer+1.
    - Then WDATA_ACK (ACK driven), then WDATA.
  - RDATA:
    - SDA_OE = ~shift[7], updated at each SCL falling edge, starting at the ADDR_ACK release edge.
    - After 8 bits, release SDA, set pointer <= pointer+1, go to RDATA_ACK.
  - RDATA_ACK: sample the initiator's bit on the 9th rising edge.
    - 0 (ACK): load regfile[pointer] and go to RDATA.
    - 1 (NACK): go to IGNORE.
- Pointer arithmetic: 8-bit, wraps 0xFF to 0x00.
- Register-file write collision: if an I2C write and Host_Wr_En hit the same cycle, the I2C write wins and the host write is dropped. Host writes to other indices in that cycle are also dropped.
- Byte aborted by START/STOP before bit 8:
  - No register write, no Wr_Valid.
  - Pointer unchanged.
- Reset asserted mid-transfer: SDA_OE=0 on the next Clock edge; the bus is released immediately.

Test Plan:
- Write 0x72, 0x41, 0x10, STOP -> ACK on all 3 bytes; Wr_Valid once with Wr_Index=0x41, Wr_Data=0x10; regfile[0x41]=0x10; pointer=0x42.
- Burst write 0x72, 0xFE, 0xAA, 0xBB, 0xCC -> regfile[0xFE]=0xAA, [0xFF]=0xBB, [0x00]=0xCC (wrap); three Wr_Valid pulses.
- Host preload [0x42]=0x60, [0x43]=0x35; then write 0x72, 0x42, repeated START, 0x73, read 2 bytes with ACK then NACK -> SDA shows 0x60, 0x35; target releases SDA after NACK; Busy low after STOP.
- Address 0x74 -> no ACK (SDA_OE stays 0 for the whole frame); no register change; Busy stays 0.
- STOP after 5 bits of a data byte -> no Wr_Valid; pointer unchanged; next transaction ACKs normally.
- Reset asserted during the ACK bit -> SDA_OE=0 within 1 Clock; state=IDLE; pointer=0.
